// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller and the PC-select
// mux that consumes pc_src.
//   state_t      : fetch FSM state encoding
//   PC_SRC_*     : next-PC select encodings driven on pc_src
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SRC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PC_SRC_JMP = 2'b10;  // jump target
    localparam logic [1:0] PC_SRC_EXC = 2'b11;  // exception vector

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Handshake bundle between the fetch controller, instruction memory, decode
// and the PC register.
//   master : fetch_ctrl side  (drives imem_req, inst_valid, pc_src, pc_en, flush)
//   slave  : environment side (drives imem_ack, dec_ready, br_taken, jump, kill)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;

    logic       imem_req;
    logic       imem_ack;
    logic       inst_valid;
    logic       dec_ready;
    logic       br_taken;
    logic       jump;
    logic       kill;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       flush;

    modport master (
        output imem_req, inst_valid, pc_src, pc_en, flush,
        input  imem_ack, dec_ready, br_taken, jump, kill
    );

    modport slave (
        input  imem_req, inst_valid, pc_src, pc_en, flush,
        output imem_ack, dec_ready, br_taken, jump, kill
    );

endinterface

// File: rtl/fetch_ctrl_wdt.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_wdt
// Watchdog for outstanding instruction-memory requests. Counts cycles while
// i_active, restarts on i_clear, and flags expiry on the TIMEOUT_CYCLES-th
// counted cycle.
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset
//   i_active   : fetch FSM is waiting on imem_ack (FETCH/DRAIN)
//   i_clear    : restart the count (state entry or redirect)
//   o_expire   : limit reached this cycle
//   o_err      : sticky timeout flag, cleared only by Rst
// -----------------------------------------------------------------------------
module fetch_ctrl_wdt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expire,
    output logic o_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expire;

    // Count k-1 is held during the k-th waiting cycle, so expiry lands on
    // cycle TIMEOUT_CYCLES itself.
    assign w_expire = !Rst && i_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_clear)
                r_cnt <= '0;
            else if (i_active)
                r_cnt <= r_cnt + 1'b1;
            if (w_expire)
                r_err <= 1'b1;
        end
    end

    assign o_expire = w_expire;
    assign o_err    = r_err | w_expire;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: issues imem reads, holds the fetched
// instruction for decode, and steers the next-PC mux / PC load enable.
// Optional feature: define FETCH_CTRL_TIMEOUT_EN to add the fetch_ctrl_wdt
// watchdog and the timeout_err output.
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   bus (master) : imem_req/imem_ack, inst_valid/dec_ready, br_taken, jump,
//                  kill, pc_src, pc_en, flush
//   timeout_err  : sticky watchdog flag (FETCH_CTRL_TIMEOUT_EN only)
// imem_req and inst_valid decode the state register only; pc_en, pc_src and
// flush are combinational from state and inputs.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_TIMEOUT_EN
    ,
    output logic         timeout_err
`endif
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_redirect;
    logic       w_pc_en;
    logic [1:0] w_pc_src;
    logic       w_flush;
    logic       w_tmo;

`ifdef FETCH_CTRL_TIMEOUT_EN
    fetch_ctrl_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_active ((r_state == S_FETCH) || (r_state == S_DRAIN)),
        .i_clear  ((w_state_nxt != r_state) || w_redirect),
        .o_expire (w_tmo),
        .o_err    (timeout_err)
    );
`else
    // The timeout limit only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_tmo            = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        w_pc_en     = 1'b0;
        w_pc_src    = PC_SRC_SEQ;
        w_flush     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                w_redirect  = bus.kill;
            end
            S_FETCH: begin
                // A watchdog expiry redirects at once but stays in FETCH so
                // the request line is never dropped.
                if (w_tmo || (bus.kill && bus.imem_ack)) begin
                    w_redirect  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (bus.kill) begin
                    w_state_nxt = S_DRAIN;
                end else if (bus.imem_ack) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.kill) begin
                    w_redirect  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (bus.dec_ready) begin
                    w_pc_en     = 1'b1;
                    w_pc_src    = bus.jump     ? PC_SRC_JMP :
                                  bus.br_taken ? PC_SRC_BR  : PC_SRC_SEQ;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Further kills are already covered by the pending redirect.
                if (bus.imem_ack || w_tmo) begin
                    w_redirect  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_redirect) begin
            w_pc_en  = 1'b1;
            w_pc_src = PC_SRC_EXC;
            w_flush  = 1'b1;
        end

        // Reset overrides any pulse in the cycle it is asserted.
        if (Rst) begin
            w_pc_en  = 1'b0;
            w_pc_src = PC_SRC_SEQ;
            w_flush  = 1'b0;
        end
    end

    assign bus.imem_req   = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign bus.inst_valid = (r_state == S_HOLD);
    assign bus.pc_en      = w_pc_en;
    assign bus.pc_src     = w_pc_src;
    assign bus.flush      = w_flush;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles FETCH/DRAIN may wait for imem_ack (used only under Configuration).
REQ-002 The block SHALL have port Clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_ack  input  1  memory data valid for the outstanding request.
REQ-006 The block SHALL have port inst_valid  output  1  fetched instruction held for decode.
REQ-007 The block SHALL have port dec_ready  input  1  decode accepts the held instruction.
REQ-008 The block SHALL have port br_taken  input  1  held instruction is a taken branch, qualified by inst_valid&&dec_ready.
REQ-009 The block SHALL have port jump  input  1  held instruction is a jump, qualified by inst_valid&&dec_ready.
REQ-010 The block SHALL have port kill  input  1  asynchronous-to-pipeline redirect to exception vector, level, sampled every cycle.
REQ-011 The block SHALL have port pc_src  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 exception vector.
REQ-012 The block SHALL have port pc_en  output  1  PC register load enable, one-cycle pulse.
REQ-013 The block SHALL have port flush  output  1  one-cycle pulse when a kill redirect takes effect.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, HOLD, DRAIN; all outputs SHALL be registered-state decoded (Moore), except pc_en/pc_src/flush, which are combinational from state and inputs.
REQ-015 IDLE SHALL move to FETCH unconditionally on the next cycle; pc_en SHALL stay 0 (first fetch uses the reset PC).
REQ-016 FETCH SHALL assert imem_req and hold it until imem_ack; on imem_ack it SHALL go to HOLD.
REQ-017 HOLD SHALL assert inst_valid; on dec_ready it SHALL pulse pc_en, drive pc_src (jump -> 10, else br_taken -> 01, else 00; jump wins if both) and go to FETCH.
REQ-018 Without dec_ready, HOLD SHALL persist indefinitely with inst_valid=1 and pc_en=0.
REQ-019 kill in IDLE or HOLD SHALL, in that cycle, pulse pc_en with pc_src=11, pulse flush, and go to FETCH; inst_valid SHALL drop next cycle; kill SHALL override dec_ready/br_taken/jump.
REQ-020 kill in FETCH without imem_ack SHALL go to DRAIN; kill in FETCH with imem_ack SHALL act as REQ-021 immediately.
REQ-021 DRAIN SHALL keep imem_req=1 until imem_ack, discard the data (inst_valid=0), then pulse pc_en with pc_src=11 and flush in the ack cycle and go to FETCH.
REQ-022 kill asserted during DRAIN SHALL have no additional effect; a request once issued SHALL never be withdrawn.
REQ-023 Outside the pulse cycles pc_src SHALL be 00, pc_en 0, flush 0.

Reset
REQ-024 Rst sampled high SHALL force state IDLE; imem_req, inst_valid, pc_en, flush SHALL be 0 and pc_src 00 in the reset cycle and the cycle after.
REQ-025 Rst SHALL win over all inputs, including mid-FETCH/DRAIN; a late imem_ack after reset SHALL be ignored while in IDLE.

Configuration
REQ-026 With FETCH_CTRL_TIMEOUT_EN defined, a counter SHALL count cycles in FETCH/DRAIN, clear on state entry or Rst, and on reaching TIMEOUT_CYCLES assert output timeout_err (sticky until Rst) and force a kill-equivalent redirect.
REQ-027 Without FETCH_CTRL_TIMEOUT_EN, the counter and the timeout_err port SHALL be absent and behaviour SHALL be exactly REQ-014..025.

Structure
REQ-028 A package fetch_ctrl_pkg SHALL hold the state enum and the four pc_src encoding constants, shared with the PC-select mux.
REQ-029 The timeout counter SHALL be a sub-module fetch_ctrl_wdt, instantiated only under FETCH_CTRL_TIMEOUT_EN.

Verification
REQ-030 Rst 1 for 2 cycles, release, imem_ack after 3 cycles -> imem_req rises cycle 1 after release, inst_valid on cycle after ack, pc_en never high before first dec_ready.
REQ-031 HOLD, dec_ready=1, br_taken=1, jump=1 -> single pc_en pulse with pc_src=10, state FETCH next.
REQ-032 HOLD, dec_ready=0 for 10 cycles then 1 with no branch -> inst_valid stable 10 cycles, one pc_en with pc_src=00.
REQ-033 FETCH, kill pulse 1 cycle, imem_ack 4 cycles later -> imem_req held throughout, inst_valid stays 0, pc_en+flush with pc_src=11 in ack cycle only.
REQ-034 Rst asserted mid-DRAIN, ack arrives next cycle -> IDLE, no pc_en, no inst_valid.
REQ-035 With FETCH_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no imem_ack -> timeout_err high at cycle 16 of FETCH, redirect with pc_src=11, timeout_err stays high until Rst.
